// File: rtl/core_prefetch_unit.sv
// Instruction prefetch unit: keeps up to MAX_OUTSTANDING AXI-lite reads in
// flight and queues returned words with their PCs in a DEPTH-entry FIFO.
// A redirect flushes the FIFO and drops responses to already-issued reads.
module core_prefetch_unit #(
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    DEPTH           = 4,
    parameter int                    MAX_OUTSTANDING = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic                  RVALID,
    output logic                  RREADY,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W:0]   DEPTH_C   = (CNT_W + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);

    // Force a PC onto a word boundary so ARADDR[1:0] is always zero.
    function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] a);
        return a & ~ADDR_WIDTH'(3);
    endfunction

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] ret_pc;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic                  arvalid_q;
    logic                  rready_q;
    logic [CNT_W-1:0]      outstanding;
    logic [CNT_W-1:0]      discard;
    logic [CNT_W-1:0]      count;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [DATA_WIDTH-1:0] mem_instr [DEPTH];
    logic [ADDR_WIDTH-1:0] mem_pc    [DEPTH];

    logic                  ar_hs;
    logic                  r_hs;
    logic                  push;
    logic                  pop;
    logic                  credit;
    logic                  load;
    logic [CNT_W-1:0]      out_after_ret;
    logic [CNT_W-1:0]      count_after;
    logic [CNT_W:0]        occ_sum;
    logic [CNT_W-1:0]      out_next;

    assign ARVALID     = arvalid_q;
    assign ARADDR      = araddr_q;
    assign RREADY      = rready_q;
    assign instr_valid = (count != '0);
    assign instr       = mem_instr[rd_ptr];
    assign instr_pc    = mem_pc[rd_ptr];

    // Handshakes, credit and next outstanding count; redirect overrides push/pop/issue.
    always_comb begin
        ar_hs         = arvalid_q & ARREADY;
        r_hs          = RVALID & rready_q;
        push          = r_hs & (discard == '0) & ~redirect_valid;
        pop           = (count != '0) & instr_ready & ~redirect_valid;
        out_after_ret = outstanding - CNT_W'(r_hs);
        count_after   = count + CNT_W'(push) - CNT_W'(pop);
        occ_sum       = {1'b0, out_after_ret} + {1'b0, count_after};
        // Reserving FIFO space per in-flight read is what lets RREADY stay high.
        credit        = (out_after_ret < MAX_OUT_C) && (occ_sum < DEPTH_C);
        load          = (~arvalid_q | ar_hs) & credit & ~redirect_valid;
        out_next      = out_after_ret + CNT_W'(load);
    end

    // Control state: AR channel, PC trackers, counters and FIFO pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            araddr_q    <= RESET_PC;
            fetch_pc    <= RESET_PC;
            ret_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            rready_q    <= 1'b1;
            outstanding <= out_next;

            // A pending AR is never withdrawn, even across a redirect.
            if (load) begin
                arvalid_q <= 1'b1;
                araddr_q  <= fetch_pc;
            end else if (ar_hs) begin
                arvalid_q <= 1'b0;
            end

            if (redirect_valid) begin
                fetch_pc <= word_align(redirect_pc);
                ret_pc   <= word_align(redirect_pc);
                // Everything still in flight, including a pending AR, is old stream.
                discard  <= out_next;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (load) begin
                    fetch_pc <= fetch_pc + WORD_STEP;
                end
                if (push) begin
                    ret_pc <= ret_pc + WORD_STEP;
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (r_hs && (discard != '0)) begin
                    discard <= discard - CNT_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count_after;
            end
        end
    end

    // FIFO storage: write the returned word with the PC it was fetched from.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr[i] <= '0;
                mem_pc[i]    <= '0;
            end
        end else if (push) begin
            mem_instr[wr_ptr] <= RDATA;
            mem_pc[wr_ptr]    <= ret_pc;
        end
    end

endmodule

// File: tb/tb_core_prefetch_unit.sv
// Bench for core_prefetch_unit: an in-order AXI-lite memory model plus an
// instruction-stream model (consecutive PCs from the last redirect target,
// data = pc ^ KEY), driven by directed phases and a randomized phase.
module tb_core_prefetch_unit;

    localparam int          DW    = 32;
    localparam int          AW    = 32;
    localparam int          DEPTH = 4;
    localparam int          MAXO  = 2;
    localparam logic [31:0] KEY   = 32'hA5A5_0000;

    logic          clk;
    logic          rst;
    logic [AW-1:0] araddr;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          rready;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          instr_valid;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_ready;

    core_prefetch_unit #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
        .MAX_OUTSTANDING(MAXO), .RESET_PC(32'h0)
    ) dut (
        .clk(clk), .rst(rst),
        .ARADDR(araddr), .ARVALID(arvalid), .ARREADY(arready),
        .RDATA(rdata), .RVALID(rvalid), .RREADY(rready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] rq [$];      // accepted, not yet returned read addresses
    logic [31:0] ar_log [$];  // accepted read addresses, in order
    logic [31:0] exp_pc;      // PC the consumer must see next
    logic [31:0] last_pop_pc;
    int          beats;
    int          pops;
    int          p_arready;
    int          p_rvalid;
    int          p_ready;
    bit          mem_on;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock cycle: account handshakes at the coming edge, check, then drive.
    task automatic tick();
        bit          ar_fire, r_fire, pop_fire, redir, stall;
        logic [31:0] stall_addr;
        ar_fire    = arvalid && arready;
        r_fire     = rvalid && rready;
        pop_fire   = instr_valid && instr_ready;
        redir      = redirect_valid;
        stall      = arvalid && !arready;
        stall_addr = araddr;
        if (pop_fire && !redir) begin
            chk("pop_pc", instr_pc, exp_pc);
            chk("pop_instr", instr, exp_pc ^ KEY);
            last_pop_pc = instr_pc;
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        if (redir) exp_pc = redirect_pc;
        if (ar_fire) begin
            rq.push_back(araddr);
            ar_log.push_back(araddr);
        end
        if (r_fire) begin
            void'(rq.pop_front());
            beats++;
        end
        @(posedge clk);
        #1;
        if (stall) begin
            chk("ar_hold_valid", arvalid, 1);
            chk("ar_hold_addr", araddr, stall_addr);
        end
        if (redir) chk("flush_empty", instr_valid, 0);
        chk("rready_high", rready, 1);
        chk("outstanding_bound", (rq.size() + int'(arvalid)) <= MAXO, 1);
        redirect_valid = 1'b0;
        rvalid      = (rq.size() > 0) && mem_on && ($urandom_range(99) < p_rvalid);
        rdata       = rvalid ? (rq[0] ^ KEY) : '0;
        arready     = $urandom_range(99) < p_arready;
        instr_ready = $urandom_range(99) < p_ready;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        rq.delete(); ar_log.delete();
        exp_pc = 32'h0; beats = 0; pops = 0;
        #2;
        chk("rst_arvalid", arvalid, 0);
        chk("rst_araddr", araddr, 32'h0);
        chk("rst_rready", rready, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", instr_pc, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("first_rready", rready, 1);
        chk("first_arvalid", arvalid, 1);
        chk("first_araddr", araddr, 32'h0);
    endtask

    task automatic wait_pop(input string tag, input logic [31:0] want_pc);
        int p0;
        p0 = pops;
        for (int i = 0; i < 40 && pops == p0; i++) tick();
        chk({tag, "_seen"}, pops > p0, 1);
        chk({tag, "_pc"}, last_pop_pc, want_pc);
    endtask

    task automatic wait_ar(input int n);
        for (int i = 0; i < 30 && ar_log.size() < n; i++) tick();
        chk("ar_count", ar_log.size() >= n, 1);
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
    endtask

    initial begin
        logic [31:0] a0, a1;
        p_arready = 100; p_rvalid = 100; p_ready = 100; mem_on = 1'b1;

        // Streaming at full rate: after warm-up a word is ready every cycle.
        do_reset();
        repeat (8) tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("stream_valid", instr_valid, 1);
        end

        // Consumer stalled: FIFO fills to DEPTH, issue stops, order kept.
        do_reset();
        p_ready = 0;
        repeat (20) tick();
        chk("fill_arvalid", arvalid, 0);
        chk("fill_beats", beats, DEPTH);
        chk("fill_valid", instr_valid, 1);
        chk("fill_inflight", rq.size(), 0);
        p_ready = 100;
        instr_ready = 1'b1;
        repeat (6) tick();
        chk("fill_pops", pops >= DEPTH, 1);

        // Redirect with two reads outstanding: both old beats dropped.
        do_reset();
        mem_on = 1'b0;
        repeat (5) tick();
        chk("r3_outstanding", rq.size(), 2);
        chk("r3_arvalid", arvalid, 0);
        do_redirect(32'h100);
        mem_on = 1'b1;
        wait_pop("r3_first", 32'h100);
        repeat (4) tick();

        // Redirect while the old AR is stalled: address held, then 0x100.
        do_reset();
        p_arready = 0;
        tick();
        ar_log.delete();
        do_redirect(32'h100);
        repeat (2) tick();
        p_arready = 100;
        arready = 1'b1;
        wait_ar(2);
        a0 = (ar_log.size() > 0) ? ar_log[0] : 32'hDEAD_BEEF;
        a1 = (ar_log.size() > 1) ? ar_log[1] : 32'hDEAD_BEEF;
        chk("r4_old_ar", a0, 32'h0);
        chk("r4_new_ar", a1, 32'h100);
        wait_pop("r4_first", 32'h100);

        // Redirect together with a return and a pop, then a second redirect.
        do_reset();
        repeat (8) tick();
        for (int i = 0; i < 20 && !(instr_valid && rvalid && instr_ready); i++) tick();
        chk("r5_setup", instr_valid && rvalid && instr_ready, 1);
        do_redirect(32'h100);
        tick();
        do_redirect(32'h200);
        wait_pop("r5_first", 32'h200);
        repeat (4) tick();

        // Address wrap-around from the top of the address space.
        do_redirect(32'hFFFF_FFFC);
        ar_log.delete();
        wait_ar(2);
        a0 = (ar_log.size() > 0) ? ar_log[0] : 32'hDEAD_BEEF;
        a1 = (ar_log.size() > 1) ? ar_log[1] : 32'hDEAD_BEEF;
        chk("wrap_ar0", a0, 32'hFFFF_FFFC);
        chk("wrap_ar1", a1, 32'h0);
        wait_pop("wrap_first", 32'hFFFF_FFFC);
        wait_pop("wrap_second", 32'h0);

        // Randomized traffic with occasional redirects.
        p_arready = 60; p_rvalid = 60; p_ready = 60;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(99) < 3) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom() & 32'hFFFF_FFFC;
            end
            tick();
        end
        p_arready = 100; p_rvalid = 100; p_ready = 100;
        repeat (20) tick();
        chk("rand_progress", pops > 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
